// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// Holds the forward-select encoding, the in-flight slot record and slot helpers.
package hazard_forward_unit_pkg;

  localparam int SLOT_REG_W = 3;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [SLOT_REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [SLOT_REG_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, rd: REG_ZERO, reg_write: 1'b0, is_load: 1'b0};

  // A slot only produces a forwardable value when it will really write a non-zero register.
  function automatic logic slot_live(input slot_t s);
    return s.valid & s.reg_write & (s.rd != REG_ZERO);
  endfunction

  function automatic logic slot_hit(input slot_t s, input logic [SLOT_REG_W-1:0] src);
    return slot_live(s) & (s.rd == src);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Priority compare of one decode source operand against the EX/MEM/WB slots.
// The youngest live producer wins; R0 and unused operands always read the register file.
module hazard_forward_unit_fwd_select
  import hazard_forward_unit_pkg::*;
(
  input  logic                  i_use,
  input  logic [SLOT_REG_W-1:0] i_src,
  input  slot_t                 i_ex,
  input  slot_t                 i_mem,
  input  slot_t                 i_wb,
  output logic [1:0]            o_sel
);

  logic w_active;
  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  assign w_active  = i_use & (i_src != REG_ZERO);
  assign w_hit_ex  = slot_hit(i_ex,  i_src);
  assign w_hit_mem = slot_hit(i_mem, i_src);
  assign w_hit_wb  = slot_hit(i_wb,  i_src);

  always_comb begin
    o_sel = FWD_REG;
    if (w_active) begin
      if (w_hit_ex)       o_sel = FWD_ALU;
      else if (w_hit_mem) o_sel = FWD_MEM;
      else if (w_hit_wb)  o_sel = FWD_WB;
      else                o_sel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: 3-slot scoreboard, forward selects, load-use stall, RF write port.
// Optional stall/forward statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_W  = 3
`ifdef HAZARD_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
)
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_ra,
  input  logic [REG_W-1:0]  id_rb,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic [REG_W-1:0]  ex_rd,
  output logic [REG_W-1:0]  mem_rd,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_reg_write
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_count,
  output logic [STAT_W-1:0] fwd_count
`endif
);

  slot_t r_ex;
  slot_t r_mem;
  slot_t r_wb;

  slot_t w_dec;
  logic  w_load_use;
  logic  w_stall;
  logic  w_take;
  logic  w_ex_live;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_dec = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};

  hazard_forward_unit_fwd_select u_fwd_a (
    .i_use (id_use_a),
    .i_src (id_ra),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (w_fwd_a)
  );

  hazard_forward_unit_fwd_select u_fwd_b (
    .i_use (id_use_b),
    .i_src (id_rb),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (w_fwd_b)
  );

  // A load in EX has no data yet; one bubble lets it reach MEM where it can be forwarded.
  assign w_ex_live  = slot_live(r_ex);
  assign w_load_use = w_ex_live & r_ex.is_load &
                      ((id_use_a & (r_ex.rd == id_ra)) | (id_use_b & (r_ex.rd == id_rb)));
  assign w_stall    = id_valid & ~flush & w_load_use;
  assign w_take     = id_valid & ~w_stall & ~flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex  <= SLOT_BUBBLE;
      r_mem <= SLOT_BUBBLE;
      r_wb  <= SLOT_BUBBLE;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_take ? w_dec : SLOT_BUBBLE;
    end
  end

  assign forward_a    = w_fwd_a;
  assign forward_b    = w_fwd_b;
  assign stall        = w_stall;
  assign ex_rd        = r_ex.rd;
  assign mem_rd       = r_mem.rd;
  assign wb_rd        = r_wb.rd;
  assign wb_reg_write = r_wb.valid & r_wb.reg_write;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] r_stall_count;
  logic [STAT_W-1:0] r_fwd_count;
  logic              w_fwd_event;

  assign w_fwd_event = w_take & ((w_fwd_a != FWD_REG) | (w_fwd_b != FWD_REG));

  // Both counters saturate rather than wrap so a long run never reports a small count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
      r_fwd_count   <= '0;
    end else begin
      if (w_stall && (r_stall_count != {STAT_W{1'b1}}))
        r_stall_count <= r_stall_count + 1'b1;
      if (w_fwd_event && (r_fwd_count != {STAT_W{1'b1}}))
        r_fwd_count <= r_fwd_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;
  assign fwd_count   = r_fwd_count;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: vector table driven through an expected-result queue,
// plus hand sequences for reset and stats (stats checks only when HAZARD_STATS_EN is defined).
module tb_hazard_forward_unit;

  logic       clk;
  logic       reset_n;
  logic       id_valid;
  logic [2:0] id_ra;
  logic [2:0] id_rb;
  logic       id_use_a;
  logic       id_use_b;
  logic [2:0] id_rd;
  logic       id_reg_write;
  logic       id_is_load;
  logic       flush;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       stall;
  logic [2:0] ex_rd;
  logic [2:0] mem_rd;
  logic [2:0] wb_rd;
  logic       wb_reg_write;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
  logic [15:0] fwd_count;
`endif

  hazard_forward_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_ra        (id_ra),
    .id_rb        (id_rb),
    .id_use_a     (id_use_a),
    .id_use_b     (id_use_b),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .ex_rd        (ex_rd),
    .mem_rd       (mem_rd),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count  (stall_count),
    .fwd_count    (fwd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       ua;
    logic       ub;
    logic [2:0] rd;
    logic       rw;
    logic       ld;
    logic       fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic [2:0] exr;
    logic [2:0] memr;
    logic [2:0] wbr;
    logic       wbw;
  } vec_t;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic [2:0] exr;
    logic [2:0] memr;
    logic [2:0] wbr;
    logic       wbw;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  vec_t tbl[23];

  function automatic vec_t mk(input logic v, input logic [2:0] ra, input logic [2:0] rb,
                              input logic ua, input logic ub, input logic [2:0] rd,
                              input logic rw, input logic ld, input logic fl,
                              input logic [1:0] fa, input logic [1:0] fb, input logic st,
                              input logic [2:0] exr, input logic [2:0] memr,
                              input logic [2:0] wbr, input logic wbw);
    vec_t r;
    r.v = v; r.ra = ra; r.rb = rb; r.ua = ua; r.ub = ub; r.rd = rd; r.rw = rw; r.ld = ld;
    r.fl = fl; r.fa = fa; r.fb = fb; r.st = st; r.exr = exr; r.memr = memr; r.wbr = wbr;
    r.wbw = wbw;
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    id_valid = 0; id_ra = 0; id_rb = 0; id_use_a = 0; id_use_b = 0;
    id_rd = 0; id_reg_write = 0; id_is_load = 0; flush = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".forward_a"}, 16'(forward_a), 16'd0);
    chk({tag, ".forward_b"}, 16'(forward_b), 16'd0);
    chk({tag, ".stall"}, 16'(stall), 16'd0);
    chk({tag, ".ex_rd"}, 16'(ex_rd), 16'd0);
    chk({tag, ".mem_rd"}, 16'(mem_rd), 16'd0);
    chk({tag, ".wb_rd"}, 16'(wb_rd), 16'd0);
    chk({tag, ".wb_reg_write"}, 16'(wb_reg_write), 16'd0);
  endtask

  initial begin
    exp_t e;
    //          v  ra rb ua ub rd rw ld fl   fa fb st exr memr wbr wbw
    tbl[0]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);  // ra=1 after reset
    tbl[1]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);  // R3 producer
    tbl[2]  = mk(1, 3, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 3, 0, 0, 0);  // ALU fwd
    tbl[3]  = mk(1, 0, 3, 0, 1, 0, 0, 0, 0,  0, 2, 0, 0, 3, 0, 0);  // MEM fwd
    tbl[4]  = mk(1, 0, 3, 0, 1, 0, 0, 0, 0,  0, 3, 0, 0, 0, 3, 1);  // WB fwd
    tbl[5]  = mk(1, 0, 3, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);  // retired
    tbl[6]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);  // R2 older
    tbl[7]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0,  0, 0, 0, 2, 0, 0, 0);  // R2 younger
    tbl[8]  = mk(1, 2, 2, 1, 1, 0, 0, 0, 0,  1, 1, 0, 2, 2, 0, 0);  // EX beats MEM
    tbl[9]  = mk(1, 0, 0, 0, 0, 5, 1, 1, 0,  0, 0, 0, 0, 2, 2, 1);  // load R5
    tbl[10] = mk(1, 0, 5, 0, 1, 0, 0, 0, 0,  0, 1, 1, 5, 0, 2, 1);  // load-use stall
    tbl[11] = mk(1, 0, 5, 0, 1, 0, 0, 0, 0,  0, 2, 0, 0, 5, 0, 0);  // bubble, fwd MEM
    tbl[12] = mk(1, 0, 0, 0, 0, 4, 1, 1, 0,  0, 0, 0, 0, 0, 5, 1);  // load R4
    tbl[13] = mk(1, 4, 0, 1, 0, 0, 0, 0, 1,  1, 0, 0, 4, 0, 0, 0);  // flush beats stall
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0, 0);  // EX bubble
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 4, 1);  // R0 producer
    tbl[16] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);  // R0 never forwards
    tbl[17] = mk(1, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);  // load R0
    tbl[18] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);  // R0 no stall, we=1
    tbl[19] = mk(1, 0, 0, 0, 0, 6, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);  // load R6 (a)
    tbl[20] = mk(1, 0, 0, 0, 0, 6, 1, 1, 0,  0, 0, 0, 6, 0, 0, 1);  // load R6 (b)
    tbl[21] = mk(1, 6, 0, 1, 0, 0, 0, 0, 0,  1, 0, 1, 6, 6, 0, 0);  // stall on younger
    tbl[22] = mk(1, 6, 0, 1, 0, 0, 0, 0, 0,  2, 0, 0, 0, 6, 6, 1);  // MEM shadows WB

    reset_n = 1'b0;
    drive_idle();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      id_valid = 1'($urandom); id_ra = 3'($urandom); id_rb = 3'($urandom);
      id_use_a = 1'($urandom); id_use_b = 1'($urandom); id_rd = 3'($urandom);
      id_reg_write = 1'($urandom); id_is_load = 1'($urandom); flush = 1'($urandom);
      #1;
      check_all_zero("reset");
    end
`ifdef HAZARD_STATS_EN
    chk("reset.stall_count", stall_count, 16'd0);
    chk("reset.fwd_count", fwd_count, 16'd0);
`endif
    @(negedge clk);
    drive_idle();
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(posedge clk);
      #1;
      id_valid = tbl[i].v; id_ra = tbl[i].ra; id_rb = tbl[i].rb;
      id_use_a = tbl[i].ua; id_use_b = tbl[i].ub; id_rd = tbl[i].rd;
      id_reg_write = tbl[i].rw; id_is_load = tbl[i].ld; flush = tbl[i].fl;
      e.fa = tbl[i].fa; e.fb = tbl[i].fb; e.st = tbl[i].st; e.exr = tbl[i].exr;
      e.memr = tbl[i].memr; e.wbr = tbl[i].wbr; e.wbw = tbl[i].wbw;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk($sformatf("vec%0d.queue_empty", i), 16'd1, 16'd0);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("vec%0d.forward_a", i), 16'(forward_a), 16'(e.fa));
        chk($sformatf("vec%0d.forward_b", i), 16'(forward_b), 16'(e.fb));
        chk($sformatf("vec%0d.stall", i), 16'(stall), 16'(e.st));
        chk($sformatf("vec%0d.ex_rd", i), 16'(ex_rd), 16'(e.exr));
        chk($sformatf("vec%0d.mem_rd", i), 16'(mem_rd), 16'(e.memr));
        chk($sformatf("vec%0d.wb_rd", i), 16'(wb_rd), 16'(e.wbr));
        chk($sformatf("vec%0d.wb_reg_write", i), 16'(wb_reg_write), 16'(e.wbw));
      end
    end

    @(posedge clk);
    #1;
    drive_idle();
`ifdef HAZARD_STATS_EN
    chk("stats.stall_count", stall_count, 16'd2);
    chk("stats.fwd_count", fwd_count, 16'd6);
`endif

    // Mid-operation reset drops in-flight entries without waiting for a clock edge.
    id_valid = 1; id_rd = 7; id_reg_write = 1;
    @(posedge clk);
    #1;
    drive_idle();
    id_valid = 1; id_ra = 7; id_use_a = 1;
    @(negedge clk);
    chk("midreset.pre_ex_rd", 16'(ex_rd), 16'd7);
    chk("midreset.pre_forward_a", 16'(forward_a), 16'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
`ifdef HAZARD_STATS_EN
    chk("midreset.stall_count", stall_count, 16'd0);
    chk("midreset.fwd_count", fwd_count, 16'd0);
`endif
    drive_idle();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
